if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage xgriscv pipeline.
- Owns the fetch PC register and next-PC selection (sequential, redirect, stall).
- Drives the asynchronous-read instruction memory and the IF/ID pipeline register.
- Downstream consumers are the decode stage and hazard unit; upstream redirects come from EX. Also counts delivered instructions and latches a sticky misaligned-redirect flag for the simulation bench.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush
XLEN, 32, address/data width

Ports:
clk  in  1  system clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
stallF  in  1  hazard unit: hold pcF
stallD  in  1  hazard unit: hold IF/ID register
flushD  in  1  hazard unit: bubble IF/ID register
redirect_valid  in  1  EX: taken branch/jump this cycle
redirect_target  in  XLEN  EX: target address
imem_addr  out  XLEN  instruction memory address (= pcF)
imem_rdata  in  32  instruction memory data, combinational from imem_addr
pcF  out  XLEN  current fetch PC
pcD  out  XLEN  PC of instruction in IF/ID
instrD  out  32  instruction in IF/ID
validD  out  1  IF/ID holds a real instruction
fetch_cnt  out  32  number of instructions loaded into IF/ID as valid
misalign_flag  out  1  sticky: a redirect target had bits[1:0]!=0

Behaviour:
- Reset (rstn=0, async, takes effect immediately): pcF=RESET_PC, pcD=0, instrD=NOP_INSTR, validD=0, fetch_cnt=0, misalign_flag=0. State is held while rstn=0.
- imem_addr = pcF, combinationally. Fetch latency is 0 cycles; the instruction appears in IF/ID one cycle after pcF presents its address.
- Next pcF, in priority order:
  1. redirect_valid: pcF <= {redirect_target[31:2],2'b00}.
  2. stallF: hold.
  3. Otherwise pcF <= pcF+4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect overrides stallF. A branch resolving in EX during a load-use stall must still be taken.
- misalign_flag <= 1 when redirect_valid and redirect_target[1:0]!=0. It clears only on reset.
- IF/ID register, in priority order:
  1. redirect_valid or flushD: pcD<=0, instrD<=NOP_INSTR, validD<=0.
  2. stallD: hold all three.
  3. Otherwise pcD<=pcF, instrD<=imem_rdata, validD<=1.
- fetch_cnt increments by 1, wrapping, on each edge where priority 3 applies. It does not increment on stall, flush, redirect or reset.
- Two-instruction branch penalty is the system contract:
  - on the redirect edge, the wrong-path instruction in IF becomes a bubble;
  - the wrong-path instruction already in ID is flushed by the hazard unit via flushE (not this block).
- stallF=0 with stallD=1 is illegal. The hazard unit never drives it. Required behaviour if it occurs: pcF advances and IF/ID holds, so one instruction is dropped. The bench checks this with an assertion.
- Reset asserted mid-operation discards IF/ID contents. The first fetch after release is at RESET_PC. validD rises on the first rising edge after rstn deasserts.

Test Plan:
- Reset release, no stalls; imem returns 32'h00000093+(addr<<18) per address -> pcF 0,4,8,C on successive edges; pcD lags pcF by one cycle; validD=1 from first edge; fetch_cnt=4 after 4 edges.
- stallF=stallD=1 for 2 cycles at pcF=0x8 -> pcF stays 0x8, pcD stays 0x4, fetch_cnt frozen; resumes to 0xC after release.
- redirect_valid=1, target=0x00c00040 at pcF=0x10 -> next pcF=0x00c00040, instrD=32'h00000013, validD=0; next edge pcD=0x00c00040, validD=1.
- redirect with stallF=1 same cycle, target=0x20 -> pcF=0x20 (redirect wins), IF/ID bubbled.
- Redirect target=0x00000046 -> pcF=0x44, misalign_flag=1 and stays 1 after further fetches until rstn=0.
- Async reset pulse (rstn=0 for 3 ns, mid-cycle) at pcF=0x30 -> outputs return to reset values immediately without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC with redirect/stall selection, IF/ID register,
// delivered-instruction counter and sticky misaligned-redirect flag.
module if_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pcD,
    output logic [31:0]     instrD,
    output logic            validD,
    output logic [31:0]     fetch_cnt,
    output logic            misalign_flag
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            misalign_q, misalign_d;
    logic            bubble;
    logic            load;

    // Redirect outranks stallF so a branch resolved during a load-use stall is still taken.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_target[XLEN-1:2], 2'b00};
        end else if (!stallF) begin
            pc_d = pc_q + XLEN'(4);
        end
        misalign_d = misalign_q | (redirect_valid && (redirect_target[1:0] != 2'b00));
    end

    always_comb begin
        bubble  = redirect_valid | flushD;
        load    = !bubble && !stallD;
        pcd_d   = pcd_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bubble) begin
            pcd_d   = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stallD) begin
            pcd_d   = pc_q;
            instr_d = imem_rdata;
            valid_d = 1'b1;
        end
        cnt_d = load ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            pcd_q      <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pcd_q      <= pcd_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr     = pc_q;
    assign pcF           = pc_q;
    assign pcD           = pcd_q;
    assign instrD        = instr_q;
    assign validD        = valid_q;
    assign fetch_cnt     = cnt_q;
    assign misalign_flag = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a
// behavioural fetch model with a combinational instruction memory.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stallF, stallD, flushD, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pcF, pcD, instrD, fetch_cnt;
    logic        validD, misalign_flag;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] m_pc, m_pcd, m_instr, m_cnt;
    logic        m_valid, m_mis;

    if_stage dut (
        .clk(clk), .rstn(rstn), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pcF(pcF), .pcD(pcD),
        .instrD(instrD), .validD(validD), .fetch_cnt(fetch_cnt), .misalign_flag(misalign_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h0000_0093 + (a << 18);
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic model_reset();
        m_pc = 32'h0; m_pcd = 32'h0; m_instr = NOP; m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] fetched_pc;
        fetched_pc = m_pc;
        if (redirect_valid && redirect_target[1:0] != 2'b00) m_mis = 1'b1;
        if (redirect_valid)  m_pc = redirect_target & 32'hFFFF_FFFC;
        else if (!stallF)    m_pc = m_pc + 32'd4;
        if (redirect_valid || flushD) begin
            m_pcd = 32'h0; m_instr = NOP; m_valid = 1'b0;
        end else if (!stallD) begin
            m_pcd = fetched_pc; m_instr = mem(fetched_pc); m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallF = 0; stallD = 0; flushD = 0; redirect_valid = 0; redirect_target = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (pcF !== 32'h0 || pcD !== 32'h0 || instrD !== NOP || validD !== 1'b0 ||
            fetch_cnt !== 32'h0 || misalign_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pcF=%h pcD=%h instrD=%h validD=%b cnt=%0d mis=%b (want 0 0 %h 0 0 0)",
                     pcF, pcD, instrD, validD, fetch_cnt, misalign_flag, NOP);
        end
        #2 rstn = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (pcF !== 32'(4 * i) || pcD !== 32'(4 * (i - 1)) || validD !== 1'b1 ||
                instrD !== mem(32'(4 * (i - 1))) || imem_addr !== pcF) begin
                errors++;
                $display("FAIL seq_edge%0d: pcF=%h pcD=%h validD=%b instrD=%h addr=%h (want pcF=%h pcD=%h valid=1 instr=%h)",
                         i, pcF, pcD, validD, instrD, imem_addr, 32'(4 * i), 32'(4 * (i - 1)), mem(32'(4 * (i - 1))));
            end
        end
        checks++;
        if (fetch_cnt !== 32'd4) begin
            errors++;
            $display("FAIL seq_count: fetch_cnt=%0d want 4", fetch_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stallF = 1; stallD = 1;
        tick(); tick();
        checks++;
        if (pcF !== 32'h8 || pcD !== 32'h4 || fetch_cnt !== 32'd2 || validD !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: pcF=%h pcD=%h cnt=%0d validD=%b want 8 4 2 1", pcF, pcD, fetch_cnt, validD);
        end
        stallF = 0; stallD = 0;
        tick();
        checks++;
        if (pcF !== 32'hC || pcD !== 32'h8 || fetch_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stall_resume: pcF=%h pcD=%h cnt=%0d want c 8 3", pcF, pcD, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) tick();
        redirect_valid = 1; redirect_target = 32'h00c0_0040;
        tick();
        redirect_valid = 0;
        checks++;
        if (pcF !== 32'h00c0_0040 || instrD !== NOP || validD !== 1'b0 || pcD !== 32'h0 ||
            fetch_cnt !== 32'd4) begin
            errors++;
            $display("FAIL redirect_edge: pcF=%h instrD=%h validD=%b pcD=%h cnt=%0d want 00c00040 %h 0 0 4",
                     pcF, instrD, validD, pcD, fetch_cnt, NOP);
        end
        tick();
        checks++;
        if (pcD !== 32'h00c0_0040 || validD !== 1'b1 || instrD !== mem(32'h00c0_0040) || pcF !== 32'h00c0_0044) begin
            errors++;
            $display("FAIL redirect_after: pcD=%h validD=%b instrD=%h pcF=%h want 00c00040 1 %h 00c00044",
                     pcD, validD, instrD, pcF, mem(32'h00c0_0040));
        end
        // Redirect during stall: redirect wins
        stallF = 1; stallD = 1; redirect_valid = 1; redirect_target = 32'h20;
        tick();
        idle_inputs();
        checks++;
        if (pcF !== 32'h20 || validD !== 1'b0 || instrD !== NOP) begin
            errors++;
            $display("FAIL redirect_stall: pcF=%h validD=%b instrD=%h want 20 0 %h", pcF, validD, instrD, NOP);
        end
        checks++;
        if (misalign_flag !== 1'b0) begin
            errors++;
            $display("FAIL misalign_aligned: flag=%b want 0", misalign_flag);
        end
        // Wrap at top of address space
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        tick();
        checks++;
        if (pcF !== 32'h0 || pcD !== 32'hFFFF_FFFC || validD !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: pcF=%h pcD=%h validD=%b want 0 fffffffc 1", pcF, pcD, validD);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        tick();
        redirect_valid = 1; redirect_target = 32'h46;
        tick();
        redirect_valid = 0;
        checks++;
        if (pcF !== 32'h44 || misalign_flag !== 1'b1) begin
            errors++;
            $display("FAIL misalign_set: pcF=%h flag=%b want 44 1", pcF, misalign_flag);
        end
        repeat (3) tick();
        checks++;
        if (misalign_flag !== 1'b1 || pcF !== 32'h50) begin
            errors++;
            $display("FAIL misalign_sticky: flag=%b pcF=%h want 1 50", misalign_flag, pcF);
        end
        do_reset();
        checks++;
        if (misalign_flag !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear: flag=%b want 0", misalign_flag);
        end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) tick();
        flushD = 1;
        tick();
        flushD = 0;
        checks++;
        if (pcF !== 32'h10 || validD !== 1'b0 || instrD !== NOP || pcD !== 32'h0 || fetch_cnt !== 32'd3) begin
            errors++;
            $display("FAIL flush: pcF=%h validD=%b instrD=%h pcD=%h cnt=%0d want 10 0 %h 0 3",
                     pcF, validD, instrD, pcD, fetch_cnt, NOP);
        end
    endtask

    task automatic test_illegal_stall();
        logic [31:0] p_pc, p_pcd, p_instr, p_cnt;
        logic        p_valid;
        do_reset();
        repeat (2) tick();
        p_pc = pcF; p_pcd = pcD; p_instr = instrD; p_valid = validD; p_cnt = fetch_cnt;
        stallF = 0; stallD = 1;
        tick();
        stallD = 0;
        checks++;
        assert (pcF === p_pc + 32'd4 && pcD === p_pcd && instrD === p_instr &&
                validD === p_valid && fetch_cnt === p_cnt)
        else begin
            errors++;
            $display("FAIL illegal_stall: pcF=%h pcD=%h instrD=%h validD=%b cnt=%0d want %h %h %h %b %0d",
                     pcF, pcD, instrD, validD, fetch_cnt, p_pc + 32'd4, p_pcd, p_instr, p_valid, p_cnt);
        end
        tick();
        checks++;
        if (pcD !== p_pc + 32'd4) begin
            errors++;
            $display("FAIL illegal_drop: pcD=%h want %h", pcD, p_pc + 32'd4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (12) tick();
        checks++;
        if (pcF !== 32'h30) begin
            errors++;
            $display("FAIL async_setup: pcF=%h want 30", pcF);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (pcF !== 32'h0 || pcD !== 32'h0 || instrD !== NOP || validD !== 1'b0 ||
            fetch_cnt !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: pcF=%h pcD=%h instrD=%h validD=%b cnt=%0d want 0 0 %h 0 0",
                     pcF, pcD, instrD, validD, fetch_cnt, NOP);
        end
        #2 rstn = 1'b1;
        model_reset();
        tick();
        checks++;
        if (pcF !== 32'h4 || pcD !== 32'h0 || validD !== 1'b1 || instrD !== mem(32'h0) || fetch_cnt !== 32'd1) begin
            errors++;
            $display("FAIL async_restart: pcF=%h pcD=%h validD=%b instrD=%h cnt=%0d want 4 0 1 %h 1",
                     pcF, pcD, validD, instrD, fetch_cnt, mem(32'h0));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stallF = ($urandom_range(0, 3) == 0);
            stallD = stallF ? $urandom_range(0, 1) : 1'b0;
            flushD = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_target = $urandom();
            if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
            tick();
            checks++;
            if (pcF !== m_pc || imem_addr !== m_pc) begin
                errors++;
                $display("FAIL rand_pcF[%0d]: got %h addr %h want %h", i, pcF, imem_addr, m_pc);
            end
            checks++;
            if (pcD !== m_pcd || instrD !== m_instr || validD !== m_valid) begin
                errors++;
                $display("FAIL rand_ifid[%0d]: got %h %h %b want %h %h %b", i, pcD, instrD, validD, m_pcd, m_instr, m_valid);
            end
            checks++;
            if (fetch_cnt !== m_cnt || misalign_flag !== m_mis) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: cnt=%0d mis=%b want %0d %b", i, fetch_cnt, misalign_flag, m_cnt, m_mis);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_flush();
        test_illegal_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
